decode_execute_register: RTL and testbench
==========================================

# decode_execute_register

Pipeline register between the decode stage (control decoder, register-file read, immediate extend) and the execute stage of the 5-stage RISC-V core. Captures decoded control signals and operands each cycle. Detects load-use hazards against the instruction currently in execute, stalling fetch/decode and inserting a bubble. Honours branch flushes from execute and counts inserted bubbles for performance monitoring.

## Interface
- DATA_WIDTH, 32, operand/PC/immediate width
- REG_ADDR_WIDTH, 5, register index width
- COUNT_WIDTH, 16, bubble counter width

- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- valid_D  input  1  decode slot holds a real instruction
- ctrl_register_file_WE_D, ctrl_srcB_D, ctrl_register_file_WA_D, ctrl_data_memory_WE_D, ctrl_result_D  input  1 each  decoded controls; ctrl_result_D=1 selects data-memory read (load)
- ctrl_ALU_op_D  input  3  ALU operation
- RD1_D, RD2_D, imm_ext_D, PC_D, PC_plus_4_D  input  DATA_WIDTH each  operands, immediate, PCs
- rs1_D, rs2_D, rd_D  input  REG_ADDR_WIDTH each  source/destination indices
- flush_E  input  1  branch/jump taken in execute; kill the instruction entering E
- same-named *_E outputs for every *_D control, data and index input above  output  matching widths  registered copies
- valid_E  output  1  execute slot holds a real instruction
- stall_FD  output  1  hold PC and fetch/decode register this cycle (combinational)
- bubble_count  output  COUNT_WIDTH  saturating count of inserted bubbles

## Operation
- load_use = valid_E & ctrl_result_E & ctrl_register_file_WE_E & (rd_E != 0) & valid_D & ((rd_E == rs1_D) | (rd_E == rs2_D)).
- stall_FD = load_use & ~flush_E (a flush kills the load-use consumer anyway).
- Per-edge update, priority order:
  1. rst: every *_E output 0, valid_E 0, bubble_count 0.
  2. flush_E or load_use: insert bubble — all ctrl_*_E, data, index outputs 0, valid_E 0.
  3. else: capture every *_D input into *_E; valid_E <= valid_D. If valid_D=0, ctrl_*_E still captured as 0 (forced), data captured as-is.
- bubble_count increments by 1 on each edge taking priority 2, saturates at 2^COUNT_WIDTH−1 (no wrap). Invalid-decode capture (priority 3, valid_D=0) does not count.
- Index 0 never triggers a hazard (x0 hard-wired zero).
- Simultaneous flush_E and load_use: one bubble, counted once, stall_FD=0.

## Timing
- Latency D→E: 1 cycle.
- stall_FD valid in the same cycle from current E-state and D inputs; no registered delay. Consumer samples it at the same edge the bubble is inserted.
- Load-use sequence: cycle n load in E, dependent in D → stall_FD=1; edge n+1 bubble in E, dependent held in D; cycle n+1 stall_FD=0 (E now bubble); edge n+2 dependent enters E. Exactly one stall cycle per load-use.
- Reset asserted mid-stall: next edge clears E-state; stall_FD falls combinationally once valid_E=0.
- Reset values: all outputs 0, including stall_FD (valid_E=0).

## Test plan
- Reset: hold rst 2 cycles with random D inputs → all *_E 0, valid_E 0, bubble_count 0, stall_FD 0.
- Plain capture: valid_D=1, RD1_D=0x1234_5678, ctrl_ALU_op_D=3'b010, rd_D=7 → next edge RD1_E=0x1234_5678, ctrl_ALU_op_E=3'b010, rd_E=7, valid_E=1, stall_FD 0.
- Load-use: load rd=5 in E (ctrl_result_E=1, WE_E=1), D has rs2_D=5 → stall_FD=1 that cycle; next edge valid_E=0, controls 0, bubble_count=1; following cycle stall_FD=0, dependent captured next edge.
- x0 and non-load: load with rd=0 matching rs1_D=0 → stall_FD 0; ALU op (ctrl_result_E=0) rd=5 vs rs1_D=5 → stall_FD 0.
- Flush vs hazard: flush_E=1 together with load-use condition → stall_FD 0, one bubble, bubble_count +1 only.
- Saturation: COUNT_WIDTH=2, force 5 consecutive flushes → bubble_count 1,2,3,3,3.

Source files
------------

// File: rtl/decode_execute_register.sv
// Decode-to-execute pipeline register with load-use hazard detection, branch flush
// and a saturating counter of inserted bubbles.
module decode_execute_register #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned COUNT_WIDTH    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      valid_D,
  input  logic                      ctrl_register_file_WE_D,
  input  logic                      ctrl_srcB_D,
  input  logic                      ctrl_register_file_WA_D,
  input  logic                      ctrl_data_memory_WE_D,
  input  logic                      ctrl_result_D,
  input  logic [2:0]                ctrl_ALU_op_D,
  input  logic [DATA_WIDTH-1:0]     RD1_D,
  input  logic [DATA_WIDTH-1:0]     RD2_D,
  input  logic [DATA_WIDTH-1:0]     imm_ext_D,
  input  logic [DATA_WIDTH-1:0]     PC_D,
  input  logic [DATA_WIDTH-1:0]     PC_plus_4_D,
  input  logic [REG_ADDR_WIDTH-1:0] rs1_D,
  input  logic [REG_ADDR_WIDTH-1:0] rs2_D,
  input  logic [REG_ADDR_WIDTH-1:0] rd_D,
  input  logic                      flush_E,
  output logic                      ctrl_register_file_WE_E,
  output logic                      ctrl_srcB_E,
  output logic                      ctrl_register_file_WA_E,
  output logic                      ctrl_data_memory_WE_E,
  output logic                      ctrl_result_E,
  output logic [2:0]                ctrl_ALU_op_E,
  output logic [DATA_WIDTH-1:0]     RD1_E,
  output logic [DATA_WIDTH-1:0]     RD2_E,
  output logic [DATA_WIDTH-1:0]     imm_ext_E,
  output logic [DATA_WIDTH-1:0]     PC_E,
  output logic [DATA_WIDTH-1:0]     PC_plus_4_E,
  output logic [REG_ADDR_WIDTH-1:0] rs1_E,
  output logic [REG_ADDR_WIDTH-1:0] rs2_E,
  output logic [REG_ADDR_WIDTH-1:0] rd_E,
  output logic                      valid_E,
  output logic                      stall_FD,
  output logic [COUNT_WIDTH-1:0]    bubble_count
);

  logic load_use;
  logic bubble;
  logic count_max;

  // x0 is hard-wired zero, so a load targeting it can never feed a consumer.
  always_comb begin
    load_use = valid_E & ctrl_result_E & ctrl_register_file_WE_E &
               (rd_E != '0) & valid_D & ((rd_E == rs1_D) | (rd_E == rs2_D));
    stall_FD = load_use & ~flush_E;
    bubble   = flush_E | load_use;
    count_max = &bubble_count;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_register_file_WE_E <= 1'b0;
      ctrl_srcB_E             <= 1'b0;
      ctrl_register_file_WA_E <= 1'b0;
      ctrl_data_memory_WE_E   <= 1'b0;
      ctrl_result_E           <= 1'b0;
      ctrl_ALU_op_E           <= '0;
      RD1_E                   <= '0;
      RD2_E                   <= '0;
      imm_ext_E               <= '0;
      PC_E                    <= '0;
      PC_plus_4_E             <= '0;
      rs1_E                   <= '0;
      rs2_E                   <= '0;
      rd_E                    <= '0;
      valid_E                 <= 1'b0;
      bubble_count            <= '0;
    end else if (bubble) begin
      ctrl_register_file_WE_E <= 1'b0;
      ctrl_srcB_E             <= 1'b0;
      ctrl_register_file_WA_E <= 1'b0;
      ctrl_data_memory_WE_E   <= 1'b0;
      ctrl_result_E           <= 1'b0;
      ctrl_ALU_op_E           <= '0;
      RD1_E                   <= '0;
      RD2_E                   <= '0;
      imm_ext_E               <= '0;
      PC_E                    <= '0;
      PC_plus_4_E             <= '0;
      rs1_E                   <= '0;
      rs2_E                   <= '0;
      rd_E                    <= '0;
      valid_E                 <= 1'b0;
      if (!count_max) begin
        bubble_count <= bubble_count + 1'b1;
      end
    end else begin
      // An empty decode slot must not carry side-effecting controls into execute.
      ctrl_register_file_WE_E <= ctrl_register_file_WE_D & valid_D;
      ctrl_srcB_E             <= ctrl_srcB_D & valid_D;
      ctrl_register_file_WA_E <= ctrl_register_file_WA_D & valid_D;
      ctrl_data_memory_WE_E   <= ctrl_data_memory_WE_D & valid_D;
      ctrl_result_E           <= ctrl_result_D & valid_D;
      ctrl_ALU_op_E           <= valid_D ? ctrl_ALU_op_D : 3'b000;
      RD1_E                   <= RD1_D;
      RD2_E                   <= RD2_D;
      imm_ext_E               <= imm_ext_D;
      PC_E                    <= PC_D;
      PC_plus_4_E             <= PC_plus_4_D;
      rs1_E                   <= rs1_D;
      rs2_E                   <= rs2_D;
      rd_E                    <= rd_D;
      valid_E                 <= valid_D;
    end
  end

endmodule

// File: tb/tb_decode_execute_register.sv
// Randomised bench for decode_execute_register: a record-level reference model of the
// execute slot plus directed load-use, x0, flush and counter-saturation scenarios.
module tb_decode_execute_register;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic        srcb;
    logic        wa;
    logic        dmwe;
    logic        res;
    logic [2:0]  alu;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } slot_t;

  logic  clk = 1'b0;
  logic  rst;
  logic  flush;
  slot_t cur;
  slot_t m;
  int    cnt16;
  int    cnt2;
  int    tests = 0;
  int    fails = 0;

  logic        e_we, e_srcb, e_wa, e_dmwe, e_res, e_valid, e_stall;
  logic [2:0]  e_alu;
  logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc4;
  logic [4:0]  e_rs1, e_rs2, e_rd;
  logic [15:0] e_cnt;

  logic        s_we, s_srcb, s_wa, s_dmwe, s_res, s_valid, s_stall;
  logic [2:0]  s_alu;
  logic [31:0] s_rd1, s_rd2, s_imm, s_pc, s_pc4;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [1:0]  s_cnt;

  always #5 clk = ~clk;

  decode_execute_register #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .valid_D(cur.valid),
    .ctrl_register_file_WE_D(cur.we), .ctrl_srcB_D(cur.srcb),
    .ctrl_register_file_WA_D(cur.wa), .ctrl_data_memory_WE_D(cur.dmwe),
    .ctrl_result_D(cur.res), .ctrl_ALU_op_D(cur.alu),
    .RD1_D(cur.rd1), .RD2_D(cur.rd2), .imm_ext_D(cur.imm), .PC_D(cur.pc),
    .PC_plus_4_D(cur.pc4), .rs1_D(cur.rs1), .rs2_D(cur.rs2), .rd_D(cur.rd),
    .flush_E(flush),
    .ctrl_register_file_WE_E(e_we), .ctrl_srcB_E(e_srcb), .ctrl_register_file_WA_E(e_wa),
    .ctrl_data_memory_WE_E(e_dmwe), .ctrl_result_E(e_res), .ctrl_ALU_op_E(e_alu),
    .RD1_E(e_rd1), .RD2_E(e_rd2), .imm_ext_E(e_imm), .PC_E(e_pc), .PC_plus_4_E(e_pc4),
    .rs1_E(e_rs1), .rs2_E(e_rs2), .rd_E(e_rd), .valid_E(e_valid), .stall_FD(e_stall),
    .bubble_count(e_cnt)
  );

  decode_execute_register #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .COUNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .valid_D(cur.valid),
    .ctrl_register_file_WE_D(cur.we), .ctrl_srcB_D(cur.srcb),
    .ctrl_register_file_WA_D(cur.wa), .ctrl_data_memory_WE_D(cur.dmwe),
    .ctrl_result_D(cur.res), .ctrl_ALU_op_D(cur.alu),
    .RD1_D(cur.rd1), .RD2_D(cur.rd2), .imm_ext_D(cur.imm), .PC_D(cur.pc),
    .PC_plus_4_D(cur.pc4), .rs1_D(cur.rs1), .rs2_D(cur.rs2), .rd_D(cur.rd),
    .flush_E(flush),
    .ctrl_register_file_WE_E(s_we), .ctrl_srcB_E(s_srcb), .ctrl_register_file_WA_E(s_wa),
    .ctrl_data_memory_WE_E(s_dmwe), .ctrl_result_E(s_res), .ctrl_ALU_op_E(s_alu),
    .RD1_E(s_rd1), .RD2_E(s_rd2), .imm_ext_E(s_imm), .PC_E(s_pc), .PC_plus_4_E(s_pc4),
    .rs1_E(s_rs1), .rs2_E(s_rs2), .rd_E(s_rd), .valid_E(s_valid), .stall_FD(s_stall),
    .bubble_count(s_cnt)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // The slot in execute is a load writing a nonzero register that decode reads.
  function automatic logic model_hazard();
    return m.valid && m.res && m.we && (m.rd != 0) && cur.valid &&
           ((m.rd == cur.rs1) || (m.rd == cur.rs2));
  endfunction

  task automatic model_update();
    if (rst) begin
      m = '0;
      cnt16 = 0;
      cnt2 = 0;
    end else if (flush || model_hazard()) begin
      m = '0;
      if (cnt16 < 65535) cnt16++;
      if (cnt2 < 3) cnt2++;
    end else begin
      m = cur;
      if (!cur.valid) begin
        m.we = 0; m.srcb = 0; m.wa = 0; m.dmwe = 0; m.res = 0; m.alu = '0;
      end
    end
  endtask

  task automatic model_check();
    chk("ctrl_E", {e_we, e_srcb, e_wa, e_dmwe, e_res, e_alu},
        {m.we, m.srcb, m.wa, m.dmwe, m.res, m.alu});
    chk("data_E", {e_rd1, e_rd2, e_imm, e_pc}, {m.rd1, m.rd2, m.imm, m.pc});
    chk("pc4_idx_E", {e_pc4, e_rs1, e_rs2, e_rd}, {m.pc4, m.rs1, m.rs2, m.rd});
    chk("valid_E", e_valid, m.valid);
    chk("stall_FD", e_stall, model_hazard() && !flush);
    chk("bubble_count", e_cnt, cnt16[15:0]);
    chk("bubble_count_sat", s_cnt, cnt2[1:0]);
  endtask

  task automatic cycle();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic rand_in(input int rs_max);
    cur.valid = ($urandom_range(0, 9) < 8);
    cur.we    = ($urandom_range(0, 3) != 0);
    cur.srcb  = $urandom_range(0, 1);
    cur.wa    = $urandom_range(0, 1);
    cur.dmwe  = $urandom_range(0, 1);
    cur.res   = $urandom_range(0, 1);
    cur.alu   = 3'($urandom);
    cur.rd1   = $urandom;
    cur.rd2   = $urandom;
    cur.imm   = $urandom;
    cur.pc    = $urandom;
    cur.pc4   = $urandom;
    cur.rs1   = 5'($urandom_range(0, rs_max));
    cur.rs2   = 5'($urandom_range(0, rs_max));
    cur.rd    = 5'($urandom_range(0, rs_max));
  endtask

  task automatic set_instr(input logic is_load, input logic [4:0] rd, input logic [4:0] rs1,
                           input logic [4:0] rs2);
    rand_in(31);
    cur.valid = 1; cur.we = 1; cur.res = is_load;
    cur.rd = rd; cur.rs1 = rs1; cur.rs2 = rs2;
  endtask

  task automatic do_reset();
    rst = 1;
    flush = 0;
    rand_in(31);
    @(posedge clk); model_update(); #1;
    rand_in(31);
    cycle();
    rst = 0;
  endtask

  initial begin
    do_reset();
    chk("rst_valid_E", e_valid, 1'b0);
    chk("rst_rd1_E", e_rd1, 32'h0);
    chk("rst_cnt", e_cnt, 16'h0);
    chk("rst_stall", e_stall, 1'b0);

    // Plain capture.
    set_instr(1'b0, 5'd7, 5'd1, 5'd2);
    cur.rd1 = 32'h1234_5678; cur.alu = 3'b010;
    cycle();
    chk("cap_rd1", e_rd1, 32'h1234_5678);
    chk("cap_alu", e_alu, 3'b010);
    chk("cap_rd", e_rd, 5'd7);
    chk("cap_valid", e_valid, 1'b1);

    // Load-use: exactly one stall cycle and one bubble.
    set_instr(1'b1, 5'd5, 5'd0, 5'd0);
    cycle();
    set_instr(1'b0, 5'd6, 5'd1, 5'd5);
    #1 chk("lu_stall", e_stall, 1'b1);
    cycle();
    chk("lu_bubble_valid", e_valid, 1'b0);
    chk("lu_bubble_res", e_res, 1'b0);
    chk("lu_cnt", e_cnt, 16'd1);
    chk("lu_stall_after", e_stall, 1'b0);
    cycle();
    chk("lu_dep_rd", e_rd, 5'd6);
    chk("lu_dep_valid", e_valid, 1'b1);

    // Load into x0 and non-load writer never stall.
    set_instr(1'b1, 5'd0, 5'd3, 5'd3);
    cycle();
    set_instr(1'b0, 5'd8, 5'd0, 5'd9);
    #1 chk("x0_stall", e_stall, 1'b0);
    set_instr(1'b0, 5'd5, 5'd3, 5'd3);
    cycle();
    set_instr(1'b0, 5'd8, 5'd5, 5'd9);
    #1 chk("alu_stall", e_stall, 1'b0);
    cycle();

    // Flush coinciding with load-use: no stall, single bubble.
    set_instr(1'b1, 5'd5, 5'd0, 5'd0);
    cycle();
    set_instr(1'b0, 5'd8, 5'd5, 5'd9);
    flush = 1;
    #1 chk("fl_lu_stall", e_stall, 1'b0);
    cycle();
    flush = 0;
    chk("fl_lu_cnt", e_cnt, 16'd2);
    chk("fl_lu_valid", e_valid, 1'b0);

    // Saturation of the 2-bit counter.
    do_reset();
    flush = 1;
    for (int i = 0; i < 5; i++) begin
      rand_in(31);
      cycle();
      chk("sat_cnt", s_cnt, (i < 3) ? 2'(i + 1) : 2'd3);
    end
    flush = 0;

    // Random traffic with a small register window to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      rand_in(3);
      flush = ($urandom_range(0, 9) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 0;
    flush = 0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
